// File: rtl/pattern_detect_ctrl.sv
// pattern_detect_ctrl: serial pattern detector with IDLE/RUN/MATCH control FSM.
// Compares the most recent cfg_len+1 received bits against cfg_pattern,
// in either overlapping or non-overlapping mode. `out` is a registered Moore flag.
// Optional feature macro: MATCH_CNT_EN adds an 8-bit saturating match counter.
module pattern_detect_ctrl #(
    parameter int PW = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [PW-1:0]         cfg_pattern,
    input  logic [$clog2(PW)-1:0] cfg_len,
    input  logic                  cfg_overlap,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  in,
    input  logic                  in_valid,
    output logic                  out,
    output logic                  busy
`ifdef MATCH_CNT_EN
    ,
    output logic [7:0]            match_cnt
`endif
);

    localparam int LW = $clog2(PW);
    localparam int FW = $clog2(PW + 1);

    typedef enum logic [1:0] {IDLE, RUN, MATCH} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   pat_r;
    logic [LW-1:0]   len_r;
    logic            ovl_r;
    // The previous PW-1 bits; together with the incoming bit they form the PW-bit window.
    logic [PW-2:0]   hist;
    logic [FW-1:0]   fill;
    logic [PW-1:0]   hist_new;
    logic [PW-1:0]   mask;
    logic [FW-1:0]   fill_new;
    logic [FW-1:0]   len_plus1;
    logic            hit;

    // Window, fill and compare as they will look once the current bit is shifted in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mask      = '0;
        hist_new  = {hist, in};
        fill_new  = (fill == FW'(PW)) ? fill : fill + FW'(1);
        len_plus1 = FW'(len_r) + FW'(1);
        for (int i = 0; i < PW; i++) begin
            mask[i] = (FW'(i) < len_plus1);
        end
        hit = (fill_new >= len_plus1) && (((hist_new ^ pat_r) & mask) == '0);
    end

    // Next-state logic: stop wins over everything, then start (IDLE) or match (RUN/MATCH).
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:       if (start) state_next = RUN;
                RUN, MATCH: state_next = (in_valid && hit) ? MATCH : RUN;
                default:    state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Configuration, history window and fill count.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r <= PW'(3'b101);
            len_r <= LW'(2);
            ovl_r <= 1'b0;
            // NOTE: the history is reset too; fill gating alone would hide it, but a known state eases debug.
            hist  <= '0;
            fill  <= '0;
        end else if (state == IDLE) begin
            if (cfg_we) begin
                pat_r <= cfg_pattern;
                len_r <= cfg_len;
                ovl_r <= cfg_overlap;
            end
            if (start && !stop) fill <= '0;
        end else if (!stop && in_valid) begin
            hist <= hist_new[PW-2:0];
            // Non-overlapping mode forgets the matched bits by emptying the window.
            fill <= (hit && !ovl_r) ? '0 : fill_new;
        end
    end

    assign out  = (state == MATCH);
    assign busy = (state != IDLE);

`ifdef MATCH_CNT_EN
    logic take;
    assign take = (state != IDLE) && !stop && in_valid && hit;

    // Saturating count of edges that enter or stay in MATCH; cleared on start.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_cnt <= '0;
        end else if (state == IDLE && start && !stop) begin
            match_cnt <= '0;
        end else if (take && match_cnt != 8'hFF) begin
            match_cnt <= match_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Testbench for pattern_detect_ctrl: directed scenarios plus randomized traffic.
// A behavioural model predicts out/busy/match_cnt per cycle into a scoreboard
// queue; an independent negedge monitor pops and compares.
module tb_pattern_detect_ctrl;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       start;
    logic       stop;
    logic       din;
    logic       in_valid;
    logic       dout;
    logic       dbusy;
    logic [7:0] dcnt;

    pattern_detect_ctrl #(.PW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .stop        (stop),
        .in          (din),
        .in_valid    (in_valid),
        .out         (dout),
        .busy        (dbusy)
`ifdef MATCH_CNT_EN
        ,
        .match_cnt   (dcnt)
`endif
    );

`ifndef MATCH_CNT_EN
    assign dcnt = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       out;
        logic       busy;
        logic [7:0] cnt;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int   pulses[$];
    int   exp_pulses[$];
    int   checks = 0;
    int   errors = 0;
    int   bit_idx = 0;

    // Behavioural reference: list of received bits and count of bits usable for a match.
    logic       m_run;
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ovl;
    int         m_bits[$];
    int         m_avail;
    int         m_cnt;
    logic       m_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model();
        int L;
        bit ok;
        if (reset) begin
            m_run = 1'b0; m_pat = 8'b101; m_len = 2; m_ovl = 1'b0;
            m_bits.delete(); m_avail = 0; m_cnt = 0; m_out = 1'b0;
        end else begin
            m_out = 1'b0;
            if (!m_run && cfg_we) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            end
            if (stop) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                if (start) begin
                    m_run = 1'b1; m_avail = 0; m_cnt = 0; m_bits.delete();
                end
            end else if (in_valid) begin
                L = m_len + 1;
                m_bits.push_back(int'(din));
                if (m_bits.size() > 16) void'(m_bits.pop_front());
                m_avail++;
                ok = (m_avail >= L);
                for (int j = 0; j < L; j++) begin
                    if (ok && m_bits[m_bits.size() - 1 - j] != int'(m_pat[j])) ok = 1'b0;
                end
                if (ok) begin
                    m_out = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    if (!m_ovl) m_avail = 0;
                end
            end
        end
    endtask

    // One clock: apply inputs, predict the post-edge outputs, queue the prediction.
    task automatic cyc(input logic r, input logic we, input logic st, input logic sp,
                       input logic iv, input logic b);
        exp_t e;
        @(negedge clk);
        reset = r; cfg_we = we; start = st; stop = sp; in_valid = iv; din = b;
        if (iv) bit_idx++;
        model();
        @(posedge clk);
        #1;
        e.out = m_out; e.busy = m_run; e.cnt = 8'(m_cnt); e.idx = bit_idx;
        sb.push_back(e);
    endtask

    // Monitor: compare each observed cycle against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out", {31'b0, dout}, {31'b0, e.out});
            check("busy", {31'b0, dbusy}, {31'b0, e.busy});
`ifdef MATCH_CNT_EN
            check("match_cnt", {24'b0, dcnt}, {24'b0, e.cnt});
`endif
            if (dout === 1'b1) pulses.push_back(e.idx);
        end
    end

    task automatic begin_test();
        bit_idx = 0;
        pulses.delete();
        exp_pulses.delete();
    endtask

    task automatic check_pulses(input string name);
        @(negedge clk);
        #1;
        check({name, "_npulses"}, pulses.size(), exp_pulses.size());
        for (int i = 0; i < exp_pulses.size(); i++) begin
            if (i < pulses.size()) check({name, "_pulse"}, pulses[i], exp_pulses[i]);
        end
    endtask

    task automatic send_stream(input logic [15:0] s);
        for (int i = 15; i >= 0; i--) cyc(0, 0, 0, 0, 1, s[i]);
    endtask

    initial begin
        logic [15:0] stream;
        stream = 16'b1101011010110101;
        reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        start = 1'b0; stop = 1'b0; din = 1'b0; in_valid = 1'b0;

        // Defaults after reset, non-overlapping 101.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        begin_test();
        send_stream(stream);
        cyc(0, 0, 0, 0, 0, 0);
        exp_pulses = '{4, 9, 14};
        check_pulses("nonoverlap");

        // Overlapping mode; config write and start on the same edge.
        cyc(0, 0, 0, 1, 0, 0);
        cfg_pattern = 8'b101; cfg_len = 3'd2; cfg_overlap = 1'b1;
        cyc(0, 1, 1, 0, 0, 0);
        begin_test();
        send_stream(stream);
        cyc(0, 0, 0, 0, 0, 0);
        exp_pulses = '{4, 6, 9, 11, 14, 16};
        check_pulses("overlap");

        // One-bit pattern: MATCH held on consecutive bits.
        cyc(0, 0, 0, 1, 0, 0);
        cfg_pattern = 8'b1; cfg_len = 3'd0; cfg_overlap = 1'b0;
        cyc(0, 1, 1, 0, 0, 0);
        begin_test();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        exp_pulses = '{1, 2, 3, 4};
        check_pulses("one_bit");
`ifdef MATCH_CNT_EN
        check("one_bit_cnt", {24'b0, dcnt}, 32'd4);
`endif

        // Stop on the completing bit wins over the match.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        begin_test();
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        check_pulses("stop");
        check("stop_out", {31'b0, dout}, 32'd0);
        check("stop_busy", {31'b0, dbusy}, 32'd0);

        // Config write during RUN ignored; in_valid gaps inside the pattern.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        begin_test();
        cyc(0, 0, 0, 0, 1, 1);
        cfg_pattern = 8'b110; cfg_len = 3'd2; cfg_overlap = 1'b0;
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        exp_pulses = '{3};
        check_pulses("cfg_in_run");

`ifdef MATCH_CNT_EN
        // Counter saturation and clear on start.
        cyc(0, 0, 0, 1, 0, 0);
        cfg_pattern = 8'b1; cfg_len = 3'd0; cfg_overlap = 1'b0;
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 1, 1);
        @(negedge clk); #1;
        check("sat_cnt", {24'b0, dcnt}, 32'd255);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        @(negedge clk); #1;
        check("restart_cnt", {24'b0, dcnt}, 32'd0);
`endif

        // Randomized traffic with occasional reset, stop, start and config writes.
        cyc(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic r, sp, st, we, iv, b;
            r  = ($urandom_range(0, 499) == 0);
            sp = ($urandom_range(0, 99) == 0);
            st = ($urandom_range(0, 19) == 0);
            we = !sp && ($urandom_range(0, 29) == 0);
            iv = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom);
            cfg_pattern = 8'($urandom);
            cfg_len     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            cfg_overlap = 1'($urandom);
            cyc(r, we, st, sp, iv, b);
        end

        @(negedge clk); #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_detect_ctrl.md
PATTERN_DETECT_CTRL -- requirements
Module: pattern_detect_ctrl

Interface
REQ-001 SHALL have parameter: PW, 8, maximum pattern width in bits (2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: cfg_we  input  1  config write strobe; honoured only in IDLE.
REQ-005 SHALL have port: cfg_pattern  input  PW  pattern; bit 0 is the last bit received.
REQ-006 SHALL have port: cfg_len  input  $clog2(PW)  pattern length minus one (0 = 1 bit).
REQ-007 SHALL have port: cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port: start  input  1  begin detection (IDLE only).
REQ-009 SHALL have port: stop  input  1  abort detection and return to IDLE.
REQ-010 SHALL have port: in  input  1  serial data bit.
REQ-011 SHALL have port: in_valid  input  1  qualifies in; bit sampled only when high.
REQ-012 SHALL have port: out  output  1  Moore match flag, high only in MATCH state.
REQ-013 SHALL have port: busy  output  1  high in RUN and MATCH.
REQ-014 SHALL have port: match_cnt  output  8  saturating match count (present only with MATCH_CNT_EN).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, MATCH; out = (state == MATCH), registered, no combinational path from in.
REQ-016 SHALL on cfg_we in IDLE latch pattern, length and overlap; cfg_we in RUN/MATCH ignored, config unchanged.
REQ-017 SHALL on start in IDLE go to RUN and clear the history fill count; start in RUN/MATCH ignored.
REQ-018 SHALL, when cfg_we and start occur together in IDLE, latch the new config and run with it.
REQ-019 SHALL in RUN/MATCH shift in into a PW-bit history and increment fill count (saturating at PW) on each in_valid cycle.
REQ-020 SHALL detect a match when fill count >= cfg_len+1 and the low cfg_len+1 history bits (new bit included) equal the low cfg_len+1 pattern bits.
REQ-021 SHALL go to MATCH on the edge sampling the completing bit; out high exactly the following cycle (1-cycle latency).
REQ-022 SHALL go MATCH->MATCH if the next sampled bit completes another match, otherwise MATCH->RUN (including in_valid low).
REQ-023 SHALL, in non-overlapping mode, zero the fill count on a match so no matched bit is reused; in overlapping mode keep history intact.
REQ-024 SHALL take stop from any state to IDLE next edge; stop has priority over start and over a match on the same edge.
REQ-025 SHALL hold state, history and out unchanged in cycles with in_valid low, except MATCH->RUN per REQ-022.

Reset
REQ-026 SHALL on reset: state IDLE, out 0, busy 0, history and fill count 0, match_cnt 0.
REQ-027 SHALL on reset load default config: pattern 'b101 (zero-extended), cfg_len 2, overlap 0.
REQ-028 SHALL let reset override all other inputs, including mid-RUN and mid-MATCH.

Configuration
REQ-029 SHALL with MATCH_CNT_EN defined provide match_cnt: +1 per entry into or stay in MATCH, saturates at 255, cleared on start.
REQ-030 SHALL with MATCH_CNT_EN undefined omit match_cnt port and counter logic; all other behaviour identical.

Verification
REQ-031 SHALL test: reset, start, defaults, bits 1101011010110101 (MSB first, in_valid=1) -> out pulses after bits 4, 9, 14 (3 matches).
REQ-032 SHALL test: same stream with cfg_overlap=1 -> out high after bits 4, 6, 9, 11, 14, 16 (6 matches; consecutive bits 4/6 non-adjacent pulses).
REQ-033 SHALL test: pattern 'b1, cfg_len 0, non-overlap, stream 1111 -> MATCH held 4 cycles, match_cnt 4.
REQ-034 SHALL test: stop asserted on the cycle bit 3 of 101 is sampled -> IDLE next cycle, out stays 0, busy 0.
REQ-035 SHALL test: cfg_we with pattern 'b110 during RUN -> ignored, 101 still detected; in_valid gaps mid-pattern -> match unaffected.
REQ-036 SHALL test (MATCH_CNT_EN): 300 matches of pattern 'b1 -> match_cnt 255; new start -> match_cnt 0.
